id_ex_stage_reg: RTL and testbench
==================================

# id_ex_stage_reg

Pipeline register between decode (D) and execute (E) in the 5-stage RISC-V core. It captures `alu_control` from the ALU decoder plus the other D-stage control and data fields, and presents them to the execute stage one cycle later. It supports hold (stall), bubble insertion (flush or invalid decode), and a saturating bubble counter for hazard-rate profiling.

## Interface
Parameters:
- `DATA_WIDTH`, 32, width of operand, immediate and PC fields
- `CNT_WIDTH`, 16, width of the bubble counter

Ports:
- `clk_i`  in  1  clock; all state updates on the rising edge
- `rst_n_i`  in  1  reset; asynchronous, active-low
- `valid_d_i`  in  1  D-stage slot holds a real instruction
- `stall_e_i`  in  1  hold all E-stage contents
- `flush_e_i`  in  1  load a bubble into E
- `alu_control_d_i`  in  4  ALU decoder output
- `reg_write_d_i`, `mem_write_d_i`, `branch_d_i`, `jump_d_i`, `alu_src_d_i`  in  1 each  D-stage control bits
- `result_src_d_i`  in  2  writeback result select
- `rs1_d_i`, `rs2_d_i`, `rd_d_i`  in  5 each  register addresses
- `rd1_d_i`, `rd2_d_i`, `imm_ext_d_i`, `pc_d_i`, `pc_plus4_d_i`  in  DATA_WIDTH each  operands, immediate, PC values
- `valid_e_o`  out  1  E-stage slot holds a real instruction
- `alu_control_e_o`  out  4  registered ALU control
- `reg_write_e_o`, `mem_write_e_o`, `branch_e_o`, `jump_e_o`, `alu_src_e_o`  out  1 each  registered control bits
- `result_src_e_o`  out  2  registered result select
- `rs1_e_o`, `rs2_e_o`, `rd_e_o`  out  5 each  registered addresses
- `rd1_e_o`, `rd2_e_o`, `imm_ext_e_o`, `pc_e_o`, `pc_plus4_e_o`  out  DATA_WIDTH each  registered data
- `bubble_count_o`  out  CNT_WIDTH  number of bubbles loaded since reset, saturating

## Operation
- Each clock edge applies one action, in this priority order: reset > flush > stall > load.
- **Reset** (`rst_n_i`=0): takes effect immediately. All outputs take their bubble values and `bubble_count_o`=0.
- **Bubble values**:
  - `valid_e_o`=0 and `alu_control_e_o`=4'b1000 (ADD).
  - All other control bits and `result_src_e_o` are 0.
  - All addresses and data fields are 0.
- **Flush** (`flush_e_i`=1): loads the bubble values and increments the counter. This applies even if `stall_e_i`=1.
- **Stall** (`stall_e_i`=1, `flush_e_i`=0): all outputs hold their value, including `valid_e_o`. The counter is unchanged.
- **Load** (neither flush nor stall):
  - If `valid_d_i`=1, every D input is captured into its E output and `valid_e_o`=1.
  - If `valid_d_i`=0, the bubble values are loaded and the counter increments. D inputs are ignored, even if they are not 0.
- **Counter**: increments by 1 per bubble load. It stays at 2^CNT_WIDTH−1 once reached and never wraps.
- The block has no decode logic. `alu_control` codes pass through unchanged; the block does not check them.

## Timing
- Latency is one cycle from D inputs to E outputs.
- All outputs come straight from flops. There is no combinational path from any input to any output.
- `stall_e_i` and `flush_e_i` are sampled at the rising edge, together with the D inputs.
- Simultaneous stall and flush: flush wins, the counter increments, and `valid_e_o`=0 on the next cycle.
- Stall held for N cycles: outputs stay constant for N cycles. The first non-stalled edge loads whatever is on the D inputs at that edge.
- Reset asserted mid-stall or mid-flush: outputs reach bubble values asynchronously. After deassertion, the first edge performs a normal priority evaluation.
- Reset deassertion is synchronised externally. The block takes no action on the deassertion edge itself.

## Test plan
- **Reset:** assert `rst_n_i`=0 between clock edges.
  - Outputs take bubble values before the next edge: `alu_control_e_o`=4'b1000, `valid_e_o`=0, `bubble_count_o`=0.
- **Load:** drive `valid_d_i`=1, `alu_control_d_i`=4'b1001, `rd1_d_i`=32'hDEAD_BEEF, `rd_d_i`=5'd7, `reg_write_d_i`=1, then clock once.
  - Exactly those values appear on the E outputs and `valid_e_o`=1.
- **Stall hold:** with a loaded instruction, set `stall_e_i`=1 for 3 edges while changing every D input.
  - E outputs stay unchanged and `bubble_count_o` stays unchanged.
  - Release the stall: the next edge loads the current D inputs.
- **Flush beats stall:** set `stall_e_i`=1 and `flush_e_i`=1 on one edge.
  - `valid_e_o`=0, `mem_write_e_o`=0, `alu_control_e_o`=4'b1000, and the counter rises by 1.
- **Invalid decode:** drive `valid_d_i`=0 with `reg_write_d_i`=1 and `mem_write_d_i`=1.
  - Both outputs are 0 after the edge and the counter rises by 1.
- **Saturation:** with `CNT_WIDTH`=4, apply 20 consecutive flushes.
  - `bubble_count_o`=4'hF, held with no wrap.

Source files
------------

// File: rtl/id_ex_stage_reg.sv
// Decode-to-execute pipeline register with stall hold, bubble insertion and a
// saturating bubble counter for hazard-rate profiling.
module id_ex_stage_reg #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  valid_d_i,
  input  logic                  stall_e_i,
  input  logic                  flush_e_i,
  input  logic [3:0]            alu_control_d_i,
  input  logic                  reg_write_d_i,
  input  logic                  mem_write_d_i,
  input  logic                  branch_d_i,
  input  logic                  jump_d_i,
  input  logic                  alu_src_d_i,
  input  logic [1:0]            result_src_d_i,
  input  logic [4:0]            rs1_d_i,
  input  logic [4:0]            rs2_d_i,
  input  logic [4:0]            rd_d_i,
  input  logic [DATA_WIDTH-1:0] rd1_d_i,
  input  logic [DATA_WIDTH-1:0] rd2_d_i,
  input  logic [DATA_WIDTH-1:0] imm_ext_d_i,
  input  logic [DATA_WIDTH-1:0] pc_d_i,
  input  logic [DATA_WIDTH-1:0] pc_plus4_d_i,
  output logic                  valid_e_o,
  output logic [3:0]            alu_control_e_o,
  output logic                  reg_write_e_o,
  output logic                  mem_write_e_o,
  output logic                  branch_e_o,
  output logic                  jump_e_o,
  output logic                  alu_src_e_o,
  output logic [1:0]            result_src_e_o,
  output logic [4:0]            rs1_e_o,
  output logic [4:0]            rs2_e_o,
  output logic [4:0]            rd_e_o,
  output logic [DATA_WIDTH-1:0] rd1_e_o,
  output logic [DATA_WIDTH-1:0] rd2_e_o,
  output logic [DATA_WIDTH-1:0] imm_ext_e_o,
  output logic [DATA_WIDTH-1:0] pc_e_o,
  output logic [DATA_WIDTH-1:0] pc_plus4_e_o,
  output logic [CNT_WIDTH-1:0]  bubble_count_o
);

  typedef struct packed {
    logic [3:0]            alu_control;
    logic                  reg_write;
    logic                  mem_write;
    logic                  branch;
    logic                  jump;
    logic                  alu_src;
    logic [1:0]            result_src;
    logic [4:0]            rs1;
    logic [4:0]            rs2;
    logic [4:0]            rd;
    logic [DATA_WIDTH-1:0] rd1;
    logic [DATA_WIDTH-1:0] rd2;
    logic [DATA_WIDTH-1:0] imm_ext;
    logic [DATA_WIDTH-1:0] pc;
    logic [DATA_WIDTH-1:0] pc_plus4;
  } stage_t;

  localparam logic [CNT_WIDTH-1:0] CntMax = '1;

  // A bubble is a harmless ADD that writes nothing.
  function automatic stage_t bubble_val();
    stage_t b;
    b             = '0;
    b.alu_control = 4'b1000;
    return b;
  endfunction

  stage_t                 stage_q, stage_d, stage_in;
  logic                   valid_q, valid_d;
  logic [CNT_WIDTH-1:0]   count_q, count_d;
  logic                   load_bubble;

  assign stage_in = '{
    alu_control: alu_control_d_i,
    reg_write:   reg_write_d_i,
    mem_write:   mem_write_d_i,
    branch:      branch_d_i,
    jump:        jump_d_i,
    alu_src:     alu_src_d_i,
    result_src:  result_src_d_i,
    rs1:         rs1_d_i,
    rs2:         rs2_d_i,
    rd:          rd_d_i,
    rd1:         rd1_d_i,
    rd2:         rd2_d_i,
    imm_ext:     imm_ext_d_i,
    pc:          pc_d_i,
    pc_plus4:    pc_plus4_d_i
  };

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    stage_d     = stage_q;
    valid_d     = valid_q;
    count_d     = count_q;
    load_bubble = 1'b0;
    if (flush_e_i) begin
      load_bubble = 1'b1;
    end else if (!stall_e_i) begin
      if (valid_d_i) begin
        valid_d = 1'b1;
        stage_d = stage_in;
      end else begin
        load_bubble = 1'b1;
      end
    end
    if (load_bubble) begin
      valid_d = 1'b0;
      stage_d = bubble_val();
      if (count_q != CntMax) count_d = count_q + 1'b1;
    end
  end

  // NOTE: non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      valid_q <= 1'b0;
      stage_q <= bubble_val();
      count_q <= '0;
    end else begin
      valid_q <= valid_d;
      stage_q <= stage_d;
      count_q <= count_d;
    end
  end

  assign valid_e_o       = valid_q;
  assign alu_control_e_o = stage_q.alu_control;
  assign reg_write_e_o   = stage_q.reg_write;
  assign mem_write_e_o   = stage_q.mem_write;
  assign branch_e_o      = stage_q.branch;
  assign jump_e_o        = stage_q.jump;
  assign alu_src_e_o     = stage_q.alu_src;
  assign result_src_e_o  = stage_q.result_src;
  assign rs1_e_o         = stage_q.rs1;
  assign rs2_e_o         = stage_q.rs2;
  assign rd_e_o          = stage_q.rd;
  assign rd1_e_o         = stage_q.rd1;
  assign rd2_e_o         = stage_q.rd2;
  assign imm_ext_e_o     = stage_q.imm_ext;
  assign pc_e_o          = stage_q.pc;
  assign pc_plus4_e_o    = stage_q.pc_plus4;
  assign bubble_count_o  = count_q;

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Scoreboard bench for id_ex_stage_reg: the driver queues expected E-stage
// contents per edge, a monitor compares them on the falling edge.
module tb_id_ex_stage_reg;

  typedef struct packed {
    logic        valid;
    logic [3:0]  alu;
    logic        rw;
    logic        mw;
    logic        br;
    logic        jp;
    logic        asrc;
    logic [1:0]  rsrc;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] imm;
    logic [31:0] pc;
    logic [31:0] pc4;
  } e_t;

  logic clk = 1'b0;
  logic rst_n;
  logic stall, flush;
  e_t   d_drv;

  always #5 clk = ~clk;

  // Main DUT outputs
  logic        valid_e, rw_e, mw_e, br_e, jp_e, as_e;
  logic [3:0]  alu_e;
  logic [1:0]  rsrc_e;
  logic [4:0]  rs1_e, rs2_e, rd_e;
  logic [31:0] rd1_e, rd2_e, imm_e, pc_e, pc4_e;
  logic [15:0] cnt16;
  // Narrow-counter DUT outputs
  logic        s_valid_e, s_rw_e, s_mw_e, s_br_e, s_jp_e, s_as_e;
  logic [3:0]  s_alu_e;
  logic [1:0]  s_rsrc_e;
  logic [4:0]  s_rs1_e, s_rs2_e, s_rd_e;
  logic [31:0] s_rd1_e, s_rd2_e, s_imm_e, s_pc_e, s_pc4_e;
  logic [3:0]  cnt4;

  e_t act, s_act;
  assign act   = {valid_e, alu_e, rw_e, mw_e, br_e, jp_e, as_e, rsrc_e, rs1_e, rs2_e, rd_e,
                  rd1_e, rd2_e, imm_e, pc_e, pc4_e};
  assign s_act = {s_valid_e, s_alu_e, s_rw_e, s_mw_e, s_br_e, s_jp_e, s_as_e, s_rsrc_e,
                  s_rs1_e, s_rs2_e, s_rd_e, s_rd1_e, s_rd2_e, s_imm_e, s_pc_e, s_pc4_e};

  id_ex_stage_reg #(.DATA_WIDTH(32), .CNT_WIDTH(16)) u_dut (
    .clk_i(clk), .rst_n_i(rst_n), .valid_d_i(d_drv.valid), .stall_e_i(stall), .flush_e_i(flush),
    .alu_control_d_i(d_drv.alu), .reg_write_d_i(d_drv.rw), .mem_write_d_i(d_drv.mw),
    .branch_d_i(d_drv.br), .jump_d_i(d_drv.jp), .alu_src_d_i(d_drv.asrc),
    .result_src_d_i(d_drv.rsrc), .rs1_d_i(d_drv.rs1), .rs2_d_i(d_drv.rs2), .rd_d_i(d_drv.rd),
    .rd1_d_i(d_drv.rd1), .rd2_d_i(d_drv.rd2), .imm_ext_d_i(d_drv.imm), .pc_d_i(d_drv.pc),
    .pc_plus4_d_i(d_drv.pc4),
    .valid_e_o(valid_e), .alu_control_e_o(alu_e), .reg_write_e_o(rw_e), .mem_write_e_o(mw_e),
    .branch_e_o(br_e), .jump_e_o(jp_e), .alu_src_e_o(as_e), .result_src_e_o(rsrc_e),
    .rs1_e_o(rs1_e), .rs2_e_o(rs2_e), .rd_e_o(rd_e), .rd1_e_o(rd1_e), .rd2_e_o(rd2_e),
    .imm_ext_e_o(imm_e), .pc_e_o(pc_e), .pc_plus4_e_o(pc4_e), .bubble_count_o(cnt16)
  );

  id_ex_stage_reg #(.DATA_WIDTH(32), .CNT_WIDTH(4)) u_sat (
    .clk_i(clk), .rst_n_i(rst_n), .valid_d_i(d_drv.valid), .stall_e_i(stall), .flush_e_i(flush),
    .alu_control_d_i(d_drv.alu), .reg_write_d_i(d_drv.rw), .mem_write_d_i(d_drv.mw),
    .branch_d_i(d_drv.br), .jump_d_i(d_drv.jp), .alu_src_d_i(d_drv.asrc),
    .result_src_d_i(d_drv.rsrc), .rs1_d_i(d_drv.rs1), .rs2_d_i(d_drv.rs2), .rd_d_i(d_drv.rd),
    .rd1_d_i(d_drv.rd1), .rd2_d_i(d_drv.rd2), .imm_ext_d_i(d_drv.imm), .pc_d_i(d_drv.pc),
    .pc_plus4_d_i(d_drv.pc4),
    .valid_e_o(s_valid_e), .alu_control_e_o(s_alu_e), .reg_write_e_o(s_rw_e),
    .mem_write_e_o(s_mw_e), .branch_e_o(s_br_e), .jump_e_o(s_jp_e), .alu_src_e_o(s_as_e),
    .result_src_e_o(s_rsrc_e), .rs1_e_o(s_rs1_e), .rs2_e_o(s_rs2_e), .rd_e_o(s_rd_e),
    .rd1_e_o(s_rd1_e), .rd2_e_o(s_rd2_e), .imm_ext_e_o(s_imm_e), .pc_e_o(s_pc_e),
    .pc_plus4_e_o(s_pc4_e), .bubble_count_o(cnt4)
  );

  // Scoreboard
  e_t          exp_q[$];
  logic [15:0] c16_q[$];
  logic [3:0]  c4_q[$];
  string       name_q[$];
  int          n_cmp  = 0;
  int          n_fail = 0;

  // Reference state as the bench expects it after each edge
  e_t          exp_e;
  logic [15:0] exp_c16;
  logic [3:0]  exp_c4;

  task automatic check(input string nm, input logic [191:0] actual, input logic [191:0] expected);
    n_cmp++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, actual, expected);
    end
  endtask

  initial begin : monitor
    e_t          e;
    logic [15:0] c16;
    logic [3:0]  c4;
    string       nm;
    forever begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        e   = exp_q.pop_front();
        c16 = c16_q.pop_front();
        c4  = c4_q.pop_front();
        nm  = name_q.pop_front();
        check({nm, ".e"},     192'(act),   192'(e));
        check({nm, ".e_sat"}, 192'(s_act), 192'(e));
        check({nm, ".cnt16"}, 192'(cnt16), 192'(c16));
        check({nm, ".cnt4"},  192'(cnt4),  192'(c4));
      end
    end
  end

  function automatic e_t bubble();
    e_t b;
    b     = '0;
    b.alu = 4'b1000;
    return b;
  endfunction

  // Distinct nonzero pattern for every field, derived from a seed
  function automatic e_t pattern(input logic [31:0] s, input logic v);
    e_t p;
    p.valid = v;
    p.alu   = s[3:0];
    p.rw    = s[4];
    p.mw    = s[5];
    p.br    = s[6];
    p.jp    = s[7];
    p.asrc  = s[8];
    p.rsrc  = s[10:9];
    p.rs1   = s[15:11];
    p.rs2   = s[20:16];
    p.rd    = s[25:21];
    p.rd1   = s ^ 32'h1111_1111;
    p.rd2   = s ^ 32'h2222_2222;
    p.imm   = s ^ 32'h4444_4444;
    p.pc    = {s[29:0], 2'b00};
    p.pc4   = {s[29:0], 2'b00} + 32'd4;
    return p;
  endfunction

  task automatic push(input string nm);
    exp_q.push_back(exp_e);
    c16_q.push_back(exp_c16);
    c4_q.push_back(exp_c4);
    name_q.push_back(nm);
  endtask

  task automatic count_bubble();
    exp_c16 = exp_c16 + 16'd1;
    if (exp_c4 != 4'hF) exp_c4 = exp_c4 + 4'd1;
  endtask

  // One clock edge with the given controls and D-stage contents
  task automatic step(input string nm, input logic st, input logic fl, input e_t d);
    @(negedge clk);
    stall = st;
    flush = fl;
    d_drv = d;
    @(posedge clk);
    if (fl) begin
      exp_e = bubble();
      count_bubble();
    end else if (!st) begin
      if (d.valid) exp_e = d;
      else begin
        exp_e = bubble();
        count_bubble();
      end
    end
    push(nm);
  endtask

  // Reset asserted between edges while stall and flush are both active
  task automatic async_reset(input string nm);
    @(negedge clk);
    stall = 1'b1;
    flush = 1'b1;
    @(posedge clk);
    #2;
    rst_n   = 1'b0;
    exp_e   = bubble();
    exp_c16 = '0;
    exp_c4  = '0;
    push(nm);
    flush = 1'b0;
    @(negedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin : driver
    e_t d;
    rst_n   = 1'b0;
    stall   = 1'b1;
    flush   = 1'b0;
    d_drv   = '0;
    exp_e   = bubble();
    exp_c16 = '0;
    exp_c4  = '0;
    #1 push("reset_init");
    @(negedge clk);
    #1 rst_n = 1'b1;

    // Directed load vector
    d = '0;
    d.valid = 1'b1;
    d.alu   = 4'b1001;
    d.rd1   = 32'hDEAD_BEEF;
    d.rd    = 5'd7;
    d.rw    = 1'b1;
    step("load_basic", 1'b0, 1'b0, d);

    // Stall for three edges while every D input moves
    step("stall_1", 1'b1, 1'b0, pattern(32'hA5A5_5A5A, 1'b1));
    step("stall_2", 1'b1, 1'b0, pattern(32'h3C3C_C3C3, 1'b0));
    step("stall_3", 1'b1, 1'b0, pattern(32'hFFFF_FFFF, 1'b1));
    step("stall_release", 1'b0, 1'b0, pattern(32'h0F1E_2D3C, 1'b1));
    step("load_all_ones", 1'b0, 1'b0, pattern(32'h07FF_FFFF, 1'b1));

    // Flush wins over stall; D inputs ignored
    step("flush_and_stall", 1'b1, 1'b1, pattern(32'h7777_7777, 1'b1));

    // Invalid decode with write enables set
    d = pattern(32'h1234_5678, 1'b0);
    d.rw = 1'b1;
    d.mw = 1'b1;
    step("invalid_decode", 1'b0, 1'b0, d);

    step("load_after_bubble", 1'b0, 1'b0, pattern(32'h2468_ACE1, 1'b1));
    step("flush_only", 1'b0, 1'b1, pattern(32'h1357_9BDF, 1'b1));
    step("stall_holds_bubble", 1'b1, 1'b0, pattern(32'h5555_AAAA, 1'b1));

    async_reset("reset_async");
    step("load_after_reset", 1'b0, 1'b0, pattern(32'h0ABC_DEF1, 1'b1));

    // Saturation of the 4-bit counter
    for (int i = 0; i < 20; i++)
      step($sformatf("sat_flush_%0d", i), 1'(i % 2), 1'b1, pattern(32'h0100_0000 + i, 1'b1));
    step("sat_invalid", 1'b0, 1'b0, pattern(32'h6666_9999, 1'b0));
    step("load_final", 1'b0, 1'b0, pattern(32'h0246_8ACE, 1'b1));

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end
    @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
